mips_pipe_stage: RTL

Parametrised inter-stage pipeline register for the MIPS datapath, successor to the fixed-field ID/EX latch. It carries an opaque data payload plus a control-bit vector between two stages. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, bubble insertion (control zeroed when invalid) and a saturating flush-drop counter. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/mips_pipe_pkg.sv | 28 ++
 rtl/mips_sat_counter.sv | 31 +++
 rtl/mips_pipe_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and default sizes for the MIPS inter-stage pipeline register.
package mips_pipe_pkg;

  // Default widths used by every stage instance unless the parent overrides them
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 12;
  localparam int DEF_CNT_W  = 16;

  // Number of beats held by one stage, 0..2
  typedef logic [1:0] occ_t;

  // Fill level of the main/skid register pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Beats held in a given state
  function automatic occ_t occ_of(input state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter that adds a small increment each cycle and sticks at all-ones.
module mips_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   sum;

  // One extra bit catches the carry; any carry means the count would wrap, so clamp instead
  always_comb begin
    sum     = {1'b0, count_q} + (W+1)'(inc);
    count_d = sum[W] ? '1 : sum[W-1:0];
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mips_pipe_stage.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush, bubble insertion and a saturating count of beats dropped by flushes.
module mips_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drops
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire;
  logic              out_fire;
  occ_t              drop_inc;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Next-state and register loads; flush overrides every transfer except delivery downstream
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Registered ready looks at where we are going, so out_ready never reaches in_ready combinationally
    in_ready_d = (state_d != ST_FULL);
  end

  // State, ready and main (output-facing) registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  // Skid register holds the second beat only while FULL
  always_ff @(posedge clk) begin
    // NOTE: skid is not reset; its contents are never visible unless it was written first.
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end

  // Beats lost to a flush: everything held, less the one leaving, plus the one arriving
  always_comb begin
    drop_inc = '0;
    if (flush) drop_inc = occ_of(state_q) - occ_t'(out_fire) + occ_t'(in_fire);
  end

  mips_sat_counter #(
    .W     (CNT_W),
    .INC_W (2)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (flush_drops)
  );

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign occupancy = occ_of(state_q);

endmodule
